// File: rtl/cpu_pkg.sv
// Shared types and default timing constants for the CPU memory-port arbiter.
// Holds the arbiter FSM states, the grant owner encoding and the latency counter width.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } arb_owner_e;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Wide enough for MEM_LAT-1 over the legal MEM_LAT range of 1..15.
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Memory latency countdown: load a start value, decrement to zero, flag zero.
// The counter holds at zero, so an extra decrement request does no harm.
module arb_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a fetch that lost STARVE_MAX data grants in a row is served next.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_pipe
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]        STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_e            state;
  arb_state_e            state_next;
  arb_owner_e            owner;
  logic [SW-1:0]         starve_cnt;
  logic [LAT_CNT_W-1:0]  cnt;
  logic                  cnt_zero;
  logic                  grant;
  logic                  grant_if;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  capture;

  arb_lat_counter #(
    .W(LAT_CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(LAT_LOAD),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_if   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant      = 1'b1;
          grant_if   = if_req && (!d_req || (starve_cnt == STARVE_LIM));
          cnt_load   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port outputs, grant bookkeeping and the per-requester read-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWNER_IF;
      starve_cnt <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      mem_en   <= grant;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (grant) begin
        if (grant_if) begin
          owner      <= OWNER_IF;
          mem_addr   <= if_addr;
          mem_we     <= 1'b0;
          starve_cnt <= '0;
        end else begin
          owner     <= OWNER_D;
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_wdata <= d_wdata;
          // Only a data grant that leaves a fetch waiting counts towards starvation.
          if (if_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
      end

      if (capture) begin
        if (owner == OWNER_IF) begin
          if_rdata <= mem_rdata;
          if_ready <= 1'b1;
        end else begin
          d_ready <= 1'b1;
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign stall_if   = if_req & ~if_ready;
  assign stall_pipe = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected completions are queued at stimulus
// time and popped when a ready pulse is seen; a second instance covers MEM_LAT=1.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          en_cyc;
    int          rdy_cyc;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } en_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_pipe;

  logic        if_req1;
  logic [31:0] if_addr1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ready1, d_ready1, mem_en1, mem_we1, stall_if1, stall_pipe1;

  logic [31:0] mem_arr [256];
  exp_t        exp_q[$];
  en_t         en_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          if_rdy_cnt = 0;
  logic [31:0] if_rdata_m, d_rdata_m;

  always #5 clk = ~clk;

  assign mem_rdata  = mem_arr[mem_addr[7:0]];
  assign mem_rdata1 = mem_arr[mem_addr1[7:0]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_pipe(stall_pipe)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_pipe(stall_pipe1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory strobe and every fetch completion as the DUT produces them.
  always @(negedge clk) begin
    if (mem_en) en_q.push_back('{cyc: cyc, we: mem_we, addr: mem_addr, wdata: mem_wdata});
    if (if_ready) if_rdy_cnt <= if_rdy_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_if, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int en_cyc);
    exp_t e;
    e.is_if   = is_if;
    e.we      = we;
    e.addr    = addr;
    e.wdata   = wdata;
    e.en_cyc  = en_cyc;
    e.rdy_cyc = en_cyc + 2;
    if (is_if) begin
      if_rdata_m = mem_arr[addr[7:0]];
      e.rdata    = if_rdata_m;
    end else begin
      if (!we) d_rdata_m = mem_arr[addr[7:0]];
      e.rdata = d_rdata_m;
    end
    exp_q.push_back(e);
  endtask

  // Waits for the next ready of one requester and compares it with the queue head.
  task automatic wait_ready(input bit is_if, input bit keep, input string tag);
    exp_t e;
    en_t  m;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_if ? if_ready : d_ready) seen = 1'b1;
    end
    check({tag, "_ready_seen"}, 64'(seen), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_queue"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    if (!seen) return;
    check({tag, "_ready_cyc"}, 64'(cyc), 64'(e.rdy_cyc));
    check({tag, "_rdata"}, 64'(is_if ? if_rdata : d_rdata), 64'(e.rdata));
    if (en_q.size() == 0) begin
      check({tag, "_en_logged"}, 64'd0, 64'd1);
    end else begin
      m = en_q.pop_front();
      check({tag, "_en_cyc"}, 64'(m.cyc), 64'(e.en_cyc));
      check({tag, "_mem_addr"}, 64'(m.addr), 64'(e.addr));
      check({tag, "_mem_we"}, 64'(m.we), 64'(e.we));
      if (e.we) begin
        check({tag, "_mem_wdata"}, 64'(m.wdata), 64'(e.wdata));
        mem_arr[m.addr[7:0]] = m.wdata;
      end
    end
    if (!keep) begin
      if (is_if) if_req = 1'b0;
      else       d_req  = 1'b0;
    end
    @(negedge clk);
    check({tag, "_ready_one_cycle"}, 64'(is_if ? if_ready : d_ready), 64'd0);
  endtask

  initial begin
    int t0;
    int rdy_before;
    int en1;
    int rdy1;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA500_0000 | 32'(i);
    mem_arr[8'h10] = 32'hDEAD_BEEF;
    if_rdata_m = '0;
    d_rdata_m  = '0;

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req1 = 1'b0; if_addr1 = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_readies", 64'({if_ready, d_ready}), 64'd0);
    check("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    check("rst_starve", 64'(dut.starve_cnt), 64'd0);
    reset = 1'b0;

    // Single fetch, MEM_LAT=2.
    @(negedge clk);
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    push_exp(1'b1, 1'b0, 32'h10, 32'h0, t0 + 1);
    wait_ready(1'b1, 1'b0, "fetch");

    // Fetch and load in the same cycle: load first, fetch grant right after IDLE.
    @(negedge clk);
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, t0 + 1);
    push_exp(1'b1, 1'b0, 32'h20, 32'h0, t0 + 5);
    @(negedge clk);
    check("both_stalls", 64'({stall_if, stall_pipe}), 64'd3);
    wait_ready(1'b0, 1'b0, "pri_load");
    check("loser_still_stalled", 64'(stall_if), 64'd1);
    wait_ready(1'b1, 1'b0, "pri_fetch");

    // Store keeps d_rdata.
    @(negedge clk);
    t0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h55;
    push_exp(1'b0, 1'b1, 32'h8, 32'h55, t0 + 1);
    wait_ready(1'b0, 1'b0, "store");
    d_we = 1'b0;

    // Request dropped early still completes.
    @(negedge clk);
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h24;
    push_exp(1'b1, 1'b0, 32'h24, 32'h0, t0 + 1);
    @(negedge clk);
    if_req = 1'b0;
    wait_ready(1'b1, 1'b0, "dropped_fetch");

    // Starvation: fetch held against back-to-back loads.
    @(negedge clk);
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b0, 32'h60 + 32'(4 * k), 32'h0, t0 + 1 + 4 * k);
    push_exp(1'b1, 1'b0, 32'h30, 32'h0, t0 + 17);
    push_exp(1'b0, 1'b0, 32'h70, 32'h0, t0 + 21);
    for (int k = 0; k < 4; k++) begin
      wait_ready(1'b0, 1'b1, "starve_load");
      d_addr = 32'h64 + 32'(4 * k);
    end
    check("starve_cnt_sat", 64'(dut.starve_cnt), 64'd4);
    wait_ready(1'b1, 1'b0, "starve_fetch");
    check("starve_cnt_clear", 64'(dut.starve_cnt), 64'd0);
    wait_ready(1'b0, 1'b0, "starve_load5");

    // Reset during WAIT abandons the access; the held fetch is reissued.
    @(negedge clk);
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h44;
    rdy_before = if_rdy_cnt;
    @(negedge clk);
    check("rw_mem_en", 64'(mem_en), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rw_outputs_zero",
          64'({mem_en, mem_we, if_ready, d_ready, |mem_addr, |mem_wdata, |if_rdata, |d_rdata}),
          64'd0);
    @(negedge clk);
    check("rw_outputs_zero2", 64'({mem_en, if_ready, d_ready, |mem_addr, |d_rdata}), 64'd0);
    reset = 1'b0;
    check("rw_no_ready", 64'(if_rdy_cnt), 64'(rdy_before));
    if (en_q.size() != 0) begin
      en_t ab;
      ab = en_q.pop_front();
      check("rw_abandoned_en_cyc", 64'(ab.cyc), 64'(t0 + 1));
    end else begin
      check("rw_abandoned_en_logged", 64'd0, 64'd1);
    end
    if_rdata_m = '0;
    d_rdata_m  = '0;
    push_exp(1'b1, 1'b0, 32'h44, 32'h0, t0 + 5);
    wait_ready(1'b1, 1'b0, "rw_reissue");
    check("rw_one_ready", 64'(if_rdy_cnt), 64'(rdy_before + 1));

    // MEM_LAT=1 instance.
    @(negedge clk);
    t0 = cyc;
    if_req1 = 1'b1; if_addr1 = 32'h10;
    en1 = -1;
    rdy1 = -1;
    for (int i = 0; i < 10 && rdy1 < 0; i++) begin
      @(negedge clk);
      if (mem_en1 && en1 < 0) en1 = cyc;
      if (if_ready1) begin
        rdy1 = cyc;
        check("lat1_rdata", 64'(if_rdata1), 64'h0000_0000_DEAD_BEEF);
        if_req1 = 1'b0;
      end
    end
    check("lat1_en_cyc", 64'(en1), 64'(t0 + 1));
    check("lat1_ready_cyc", 64'(rdy1), 64'(t0 + 2));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
